control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Main instruction-decode control unit of the game-platform processor.
- Maps the 6-bit opcode to the datapath control strobes: stack, branch, memory, ALU source and register write.
- Also passes through the ALU operation code.
- Decode is purely combinational. The single clock only drives a sticky illegal-opcode flag used for debug.

Parameters:
- OPW, 6, opcode width and ALUOp width (fixed at 6; not intended to be overridden).

Ports:
- clk  input  1  system clock; used only by the illegal_opcode register
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  current micro-op / instruction opcode
- StackPush  output  1  push return address onto call stack
- StackPop  output  1  pop return address from call stack
- BranchMode  output  1  1 = unconditional/absolute branch target mode, 0 = conditional
- BranchSrc  output  1  branch/flag source select
- Branch  output  1  branch/jump taken request
- MemRead  output  1  data memory read enable
- MemToReg  output  1  register write-back selects memory data
- ALUOp  output  6  ALU operation code
- MemWrite  output  1  data memory write enable
- ALUSrc  output  1  ALU B operand select (1 = immediate)
- RegWrite  output  1  register file write enable
- illegal_opcode  output  1  sticky flag, set when an undefined opcode is decoded

Behaviour:
- All control outputs except illegal_opcode are combinational functions of opcode and rst_n. There is no latency: outputs are valid within the same cycle that opcode changes.
- Opcode map and outputs below. Flag order is StackPush, StackPop, BranchMode, BranchSrc, Branch, MemRead, MemToReg, MemWrite, ALUSrc, RegWrite. Any flag not listed is 0.
  - 000000 LW_1: MemRead, MemToReg, ALUSrc, RegWrite = 1
  - 000001 LW_2: MemRead, MemToReg, RegWrite = 1
  - 000010 LW_3: ALUSrc, RegWrite = 1
  - 000011 SW_1: MemWrite, ALUSrc = 1
  - 000100 SW_2: MemWrite = 1
  - 000101 MOV, 000110 ADD, 000111 SUB, 001000 MUL, 001001 DIV, 001010 AND, 001011 OR, 001100 SHL, 001101 SHR, 001111 NOT: RegWrite = 1
  - 001110 CMP: BranchSrc = 1 only (RegWrite = 0)
  - 010000 JR: BranchMode, Branch = 1
  - 010001 JPC: Branch, ALUSrc = 1
  - 010010 BRFL: BranchMode, Branch, ALUSrc = 1
  - 010011 CALL: StackPush, BranchMode, Branch, RegWrite = 1
  - 010100 RET: StackPop, BranchMode, BranchSrc, Branch = 1
  - 010101 NOP: all flags 0
- ALUOp equals opcode for every defined opcode 000000..010101.
- Undefined opcodes 010110..111111 (including the reserved sprite/video codes 010110..011011):
  - all flags 0
  - ALUOp = 010101 (NOP)
  - no stack, memory or register side effect is possible.
- Reset:
  - While rst_n = 0, all control outputs are forced to NOP values regardless of opcode: flags 0, ALUOp = 010101.
  - This is asynchronous and takes effect immediately on the falling edge of rst_n.
  - On release of rst_n, outputs follow opcode combinationally at once.
- illegal_opcode:
  - Flip-flop, cleared asynchronously to 0 when rst_n = 0.
  - Set to 1 on any rising clk edge where rst_n = 1 and opcode >= 010110.
  - Remains 1 until the next reset.
- X/Z bits on opcode drive NOP outputs, matching the default decode branch. The decoder has no latches; every output is assigned on every path.

Test Plan:
- rst_n = 1, sweep all 22 defined opcodes 000000..010101 with 10 ns settle each. Check every output against the map, e.g.:
  - CALL (010011): StackPush = 1, BranchMode = 1, Branch = 1, RegWrite = 1, ALUOp = 010011, all others 0.
  - RET (010100): StackPop = 1, BranchMode = 1, BranchSrc = 1, Branch = 1, ALUOp = 010100, all others 0.
- Sweep undefined opcodes 010110..111111: all flags 0, ALUOp = 010101.
- Apply opcode = 000000 (LW_1), then pull rst_n low mid-cycle. Outputs drop to NOP immediately (MemRead = 0, ALUOp = 010101). Release rst_n: MemRead = 1, MemToReg = 1, ALUSrc = 1, RegWrite = 1.
- After reset, clock only defined opcodes: illegal_opcode stays 0. Apply 011110 for one clk edge: illegal_opcode = 1. Return to ADD: flag stays 1; ADD still gives RegWrite = 1, ALUOp = 000110.
- Assert rst_n = 0 with illegal_opcode = 1: flag clears to 0 without a clock edge.
- Back-to-back SW_1 -> SW_2 -> LW_3: MemWrite = 1, ALUSrc = 1 -> MemWrite = 1, ALUSrc = 0 -> MemWrite = 0, ALUSrc = 1, RegWrite = 1, each valid the same cycle.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: instruction-decode control unit for the game-platform processor.
// Decodes the 6-bit opcode into datapath control strobes and passes the ALU
// operation code through. Decode is purely combinational; the clock drives only
// the sticky illegal-opcode debug flag.
module control_unit #(
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    output logic           StackPush,
    output logic           StackPop,
    output logic           BranchMode,
    output logic           BranchSrc,
    output logic           Branch,
    output logic           MemRead,
    output logic           MemToReg,
    output logic [OPW-1:0] ALUOp,
    output logic           MemWrite,
    output logic           ALUSrc,
    output logic           RegWrite,
    output logic           illegal_opcode
);

    // Individual control strobes packed in a vector, MSB first:
    // StackPush, StackPop, BranchMode, BranchSrc, Branch,
    // MemRead, MemToReg, MemWrite, ALUSrc, RegWrite
    localparam logic [9:0] F_PUSH  = 10'b10000_00000;
    localparam logic [9:0] F_POP   = 10'b01000_00000;
    localparam logic [9:0] F_BMODE = 10'b00100_00000;
    localparam logic [9:0] F_BSRC  = 10'b00010_00000;
    localparam logic [9:0] F_BR    = 10'b00001_00000;
    localparam logic [9:0] F_MR    = 10'b00000_10000;
    localparam logic [9:0] F_M2R   = 10'b00000_01000;
    localparam logic [9:0] F_MW    = 10'b00000_00100;
    localparam logic [9:0] F_ASRC  = 10'b00000_00010;
    localparam logic [9:0] F_RW    = 10'b00000_00001;

    localparam logic [OPW-1:0] OP_LW_1 = 6'b000000;
    localparam logic [OPW-1:0] OP_LW_2 = 6'b000001;
    localparam logic [OPW-1:0] OP_LW_3 = 6'b000010;
    localparam logic [OPW-1:0] OP_SW_1 = 6'b000011;
    localparam logic [OPW-1:0] OP_SW_2 = 6'b000100;
    localparam logic [OPW-1:0] OP_MOV  = 6'b000101;
    localparam logic [OPW-1:0] OP_ADD  = 6'b000110;
    localparam logic [OPW-1:0] OP_SUB  = 6'b000111;
    localparam logic [OPW-1:0] OP_MUL  = 6'b001000;
    localparam logic [OPW-1:0] OP_DIV  = 6'b001001;
    localparam logic [OPW-1:0] OP_AND  = 6'b001010;
    localparam logic [OPW-1:0] OP_OR   = 6'b001011;
    localparam logic [OPW-1:0] OP_SHL  = 6'b001100;
    localparam logic [OPW-1:0] OP_SHR  = 6'b001101;
    localparam logic [OPW-1:0] OP_CMP  = 6'b001110;
    localparam logic [OPW-1:0] OP_NOT  = 6'b001111;
    localparam logic [OPW-1:0] OP_JR   = 6'b010000;
    localparam logic [OPW-1:0] OP_JPC  = 6'b010001;
    localparam logic [OPW-1:0] OP_BRFL = 6'b010010;
    localparam logic [OPW-1:0] OP_CALL = 6'b010011;
    localparam logic [OPW-1:0] OP_RET  = 6'b010100;
    localparam logic [OPW-1:0] OP_NOP  = 6'b010101;

    logic [9:0]     flags;
    logic [OPW-1:0] alu_op;
    logic           illegal_d;
    logic           illegal_q;

    // Opcode decode; reset, undefined and X/Z opcodes all fall to NOP values
    always_comb begin
        flags  = '0;
        alu_op = OP_NOP;
        if (rst_n) begin
            alu_op = opcode;
            case (opcode)
                OP_LW_1: flags = F_MR | F_M2R | F_ASRC | F_RW;
                OP_LW_2: flags = F_MR | F_M2R | F_RW;
                OP_LW_3: flags = F_ASRC | F_RW;
                OP_SW_1: flags = F_MW | F_ASRC;
                OP_SW_2: flags = F_MW;
                OP_MOV, OP_ADD, OP_SUB, OP_MUL, OP_DIV,
                OP_AND, OP_OR, OP_SHL, OP_SHR, OP_NOT:
                         flags = F_RW;
                OP_CMP:  flags = F_BSRC;
                OP_JR:   flags = F_BMODE | F_BR;
                OP_JPC:  flags = F_BR | F_ASRC;
                OP_BRFL: flags = F_BMODE | F_BR | F_ASRC;
                OP_CALL: flags = F_PUSH | F_BMODE | F_BR | F_RW;
                OP_RET:  flags = F_POP | F_BMODE | F_BSRC | F_BR;
                OP_NOP:  flags = '0;
                default: begin
                    flags  = '0;
                    alu_op = OP_NOP;
                end
            endcase
        end
    end

    // Sticky flag: once any opcode above NOP is clocked in, hold until reset
    always_comb begin
        illegal_d = illegal_q | (opcode > OP_NOP);
    end

    // Debug flag register, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign {StackPush, StackPop, BranchMode, BranchSrc, Branch,
            MemRead, MemToReg, MemWrite, ALUSrc, RegWrite} = flags;
    assign ALUOp          = alu_op;
    assign illegal_opcode = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table-driven and randomized checks of the control_unit decoder
// and its sticky illegal-opcode flag.
module tb_control_unit;

    typedef struct {
        logic [5:0] op;
        logic [9:0] flags;
        string      name;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       StackPush, StackPop, BranchMode, BranchSrc, Branch;
    logic       MemRead, MemToReg, MemWrite, ALUSrc, RegWrite;
    logic [5:0] ALUOp;
    logic       illegal_opcode;

    vec_t vecs[22];
    int   checks;
    int   failures;
    logic model_ill;

    control_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .opcode         (opcode),
        .StackPush      (StackPush),
        .StackPop       (StackPop),
        .BranchMode     (BranchMode),
        .BranchSrc      (BranchSrc),
        .Branch         (Branch),
        .MemRead        (MemRead),
        .MemToReg       (MemToReg),
        .ALUOp          (ALUOp),
        .MemWrite       (MemWrite),
        .ALUSrc         (ALUSrc),
        .RegWrite       (RegWrite),
        .illegal_opcode (illegal_opcode)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: look up the opcode in the spec table; anything else or reset gives NOP
    function automatic logic [15:0] refDecode(input logic [5:0] op, input logic rn);
        logic [15:0] r;
        r = {10'b0, 6'b010101};
        if (rn) begin
            for (int i = 0; i < 22; i++) begin
                if (vecs[i].op == op) r = {vecs[i].flags, op};
            end
        end
        return r;
    endfunction

    // Compare all decode outputs and the sticky flag against expectations
    task automatic checkOutput(input string name, input logic [15:0] exp_out, input logic exp_ill);
        logic [15:0] act;
        act = {StackPush, StackPop, BranchMode, BranchSrc, Branch,
               MemRead, MemToReg, MemWrite, ALUSrc, RegWrite, ALUOp};
        checks++;
        if (act !== exp_out) begin
            failures++;
            $display("[TB] FAIL %s decode: got flags=%b alu=%b, expected flags=%b alu=%b",
                     name, act[15:6], act[5:0], exp_out[15:6], exp_out[5:0]);
        end
        checks++;
        if (illegal_opcode !== exp_ill) begin
            failures++;
            $display("[TB] FAIL %s illegal_opcode: got %b, expected %b", name, illegal_opcode, exp_ill);
        end
    endtask

    // Drive opcode/reset at the falling edge and check the same-cycle decode
    task automatic applyStimulus(input string name, input logic [5:0] op, input logic rn);
        @(negedge clk);
        opcode = op;
        rst_n  = rn;
        if (!rn) model_ill = 1'b0;
        #1;
        checkOutput(name, refDecode(op, rn), model_ill);
    endtask

    // Let one rising edge happen and update the sticky flag model
    task automatic clockEdge(input string name);
        @(posedge clk);
        if (rst_n === 1'b1 && opcode >= 6'd22) model_ill = 1'b1;
        #1;
        checkOutput(name, refDecode(opcode, rst_n), model_ill);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        model_ill = 1'b0;

        // Flag order: Push Pop BMode BSrc Br | MemRd MemToReg MemWr ALUSrc RegWr
        vecs[0]  = '{6'd0,  10'b00000_11011, "LW_1"};
        vecs[1]  = '{6'd1,  10'b00000_11001, "LW_2"};
        vecs[2]  = '{6'd2,  10'b00000_00011, "LW_3"};
        vecs[3]  = '{6'd3,  10'b00000_00110, "SW_1"};
        vecs[4]  = '{6'd4,  10'b00000_00100, "SW_2"};
        vecs[5]  = '{6'd5,  10'b00000_00001, "MOV"};
        vecs[6]  = '{6'd6,  10'b00000_00001, "ADD"};
        vecs[7]  = '{6'd7,  10'b00000_00001, "SUB"};
        vecs[8]  = '{6'd8,  10'b00000_00001, "MUL"};
        vecs[9]  = '{6'd9,  10'b00000_00001, "DIV"};
        vecs[10] = '{6'd10, 10'b00000_00001, "AND"};
        vecs[11] = '{6'd11, 10'b00000_00001, "OR"};
        vecs[12] = '{6'd12, 10'b00000_00001, "SHL"};
        vecs[13] = '{6'd13, 10'b00000_00001, "SHR"};
        vecs[14] = '{6'd14, 10'b00010_00000, "CMP"};
        vecs[15] = '{6'd15, 10'b00000_00001, "NOT"};
        vecs[16] = '{6'd16, 10'b00101_00000, "JR"};
        vecs[17] = '{6'd17, 10'b00001_00010, "JPC"};
        vecs[18] = '{6'd18, 10'b00101_00010, "BRFL"};
        vecs[19] = '{6'd19, 10'b10101_00001, "CALL"};
        vecs[20] = '{6'd20, 10'b01111_00000, "RET"};
        vecs[21] = '{6'd21, 10'b00000_00000, "NOP"};

        rst_n  = 1'b0;
        opcode = 6'd0;
        #3;
        checkOutput("reset_state", {10'b0, 6'b010101}, 1'b0);

        // Defined opcodes, each clocked: flag must stay clear
        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i].name, vecs[i].op, 1'b1);
            checkOutput({vecs[i].name, "_table"}, {vecs[i].flags, vecs[i].op}, 1'b0);
            clockEdge({vecs[i].name, "_clk"});
        end

        // Undefined opcodes decode as NOP and set the sticky flag
        for (int op = 22; op < 64; op++) begin
            applyStimulus($sformatf("undef_%0d", op), 6'(op), 1'b1);
            checkOutput($sformatf("undef_%0d_nop", op), {10'b0, 6'b010101}, model_ill);
            clockEdge($sformatf("undef_%0d_clk", op));
        end

        // LW_1 with reset pulled low mid-cycle and released again
        applyStimulus("lw1_pre_reset", 6'd0, 1'b1);
        #2;
        rst_n     = 1'b0;
        model_ill = 1'b0;
        #1;
        checkOutput("lw1_in_reset", {10'b0, 6'b010101}, 1'b0);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("lw1_released", {10'b00000_11011, 6'd0}, 1'b0);

        // Sticky flag: defined opcodes keep it clear, one illegal edge sets it
        applyStimulus("ill_add0", 6'd6, 1'b1);
        clockEdge("ill_add0_clk");
        applyStimulus("ill_call", 6'd19, 1'b1);
        clockEdge("ill_call_clk");
        checkOutput("ill_still_clear", {10'b10101_00001, 6'd19}, 1'b0);
        applyStimulus("ill_30", 6'b011110, 1'b1);
        clockEdge("ill_30_clk");
        checkOutput("ill_set", {10'b0, 6'b010101}, 1'b1);
        applyStimulus("ill_add1", 6'd6, 1'b1);
        clockEdge("ill_add1_clk");
        checkOutput("ill_sticky_add", {10'b00000_00001, 6'b000110}, 1'b1);
        #2;
        rst_n     = 1'b0;
        model_ill = 1'b0;
        #1;
        checkOutput("ill_async_clear", {10'b0, 6'b010101}, 1'b0);

        // Back-to-back store and load micro-ops, each valid in its own cycle
        applyStimulus("sw1", 6'd3, 1'b1);
        checkOutput("b2b_sw1", {10'b00000_00110, 6'd3}, 1'b0);
        applyStimulus("sw2", 6'd4, 1'b1);
        checkOutput("b2b_sw2", {10'b00000_00100, 6'd4}, 1'b0);
        applyStimulus("lw3", 6'd2, 1'b1);
        checkOutput("b2b_lw3", {10'b00000_00011, 6'd2}, 1'b0);

        // Randomized opcodes with occasional reset against the reference model
        for (int n = 0; n < 300; n++) begin
            applyStimulus($sformatf("rand_%0d", n), 6'($urandom_range(0, 63)),
                          ($urandom_range(0, 9) != 0));
            clockEdge($sformatf("rand_%0d_clk", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
